// File: rtl/regfile_mp.sv
// Multi-port integer register file: two prioritized write ports, NREAD registered
// read ports plus a debug tap, same-cycle bypass and a post-reset zero scrub.

module regfile_mp_rport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stall,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] nxt;

    // Port 1 bypass is checked first so it wins a same-address collision.
    always_comb begin
        nxt = mem_q;
        if (ZERO_REG != 0 && addr == '0)
            nxt = '0;
        else if (wen1 && wa1 == addr)
            nxt = wd1;
        else if (wen0 && wa0 == addr)
            nxt = wd0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (!run)
            q <= '0;
        else if (!stall)
            q <= nxt;
    end
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       wa0,
    input  logic [DATA_W-1:0]       wd0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       wa1,
    input  logic [DATA_W-1:0]       wd1,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD*DATA_W-1:0] rd,
    input  logic [ADDR_W-1:0]       dbg_addr,
    output logic [DATA_W-1:0]       dbg_data,
    output logic                    ready
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NLANE = NREAD + 1;

    typedef enum logic {SCRUB, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] scrub_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run, wen0, wen1;

    // Lane NREAD is the debug tap; it shares the read-port datapath.
    logic [NLANE-1:0][ADDR_W-1:0] lane_addr;
    logic [NLANE-1:0][DATA_W-1:0] lane_mem;
    logic [NLANE-1:0][DATA_W-1:0] lane_q;

    assign run  = (state == RUN) && !rst;
    assign wen0 = run && we0 && !(ZERO_REG != 0 && wa0 == '0);
    assign wen1 = run && we1 && !(ZERO_REG != 0 && wa1 == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCRUB;
            scrub_cnt <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                SCRUB: begin
                    scrub_cnt <= scrub_cnt + 1'b1;
                    if (scrub_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN:     ready <= 1'b1;
                default: state <= SCRUB;
            endcase
        end
    end

    // Storage has no reset; the scrub walk is what clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == SCRUB) begin
                mem[scrub_cnt] <= '0;
            end else begin
                if (wen0) mem[wa0] <= wd0;
                if (wen1) mem[wa1] <= wd1;
            end
        end
    end

    assign lane_addr[NREAD] = dbg_addr;
    assign dbg_data         = lane_q[NREAD];

    generate
        for (genvar i = 0; i < NREAD; i++) begin : g_map
            assign lane_addr[i]               = ra[i*ADDR_W +: ADDR_W];
            assign rd[i*DATA_W +: DATA_W]     = lane_q[i];
        end

        for (genvar i = 0; i < NLANE; i++) begin : g_lane
            assign lane_mem[i] = mem[lane_addr[i]];

            regfile_mp_rport #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .clk   (clk),
                .rst   (rst),
                .run   (run),
                .stall (stall),
                .addr  (lane_addr[i]),
                .mem_q (lane_mem[i]),
                .wen0  (wen0),
                .wa0   (wa0),
                .wd0   (wd0),
                .wen1  (wen1),
                .wa1   (wa1),
                .wd1   (wd1),
                .q     (lane_q[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed checks of regfile_mp against a behavioural array model.

module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst, stall, we0, we1;
    logic [AW-1:0]    wa0, wa1, dbg_addr;
    logic [DW-1:0]    wd0, wd1;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [DW-1:0]    dbg_data;
    logic             ready;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_rd [NR];
    logic [DW-1:0] exp_dbg;
    logic          exp_ready;
    int            scrub_left = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return mem_m[a];
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < NR; i++) exp_rd[i] = '0;
            exp_dbg    = '0;
            exp_ready  = 1'b0;
            scrub_left = DEPTH;
        end else if (scrub_left > 0) begin
            for (int i = 0; i < NR; i++) exp_rd[i] = '0;
            exp_dbg = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            scrub_left--;
            if (scrub_left == 0) exp_ready = 1'b1;
        end else begin
            if (!stall) begin
                for (int i = 0; i < NR; i++) exp_rd[i] = ref_read(ra[i*AW +: AW]);
                exp_dbg = ref_read(dbg_addr);
            end
            if (we0 && wa0 != 0) mem_m[wa0] = wd0;
            if (we1 && wa1 != 0) mem_m[wa1] = wd1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; we0 = 0; we1 = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    task automatic test_reset();
        idle(); ra = '0; dbg_addr = '0;
        rst = 1;
        step();
        total++;
        if (rd !== '0) begin bad++; $display("FAIL reset_rd got=%h want=0", rd); end
        total++;
        if (dbg_data !== '0) begin bad++; $display("FAIL reset_dbg got=%h want=0", dbg_data); end
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    endtask

    task automatic test_scrub();
        int n;
        idle();
        rst = 1;
        step();
        rst = 0;
        we0 = 1; wa0 = 5'd3; wd0 = 32'hDEAD;
        set_ra(0, 5'd3);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            total++;
            if (rd !== '0) begin bad++; $display("FAIL scrub_rd_zero got=%h want=0", rd); end
            step();
        end
        total++;
        if (n != DEPTH) begin bad++; $display("FAIL scrub_len got=%0d want=%0d", n, DEPTH); end
        idle();
        set_ra(0, 5'd3);
        step();
        total++;
        if (rd[0 +: DW] !== 32'h0) begin bad++; $display("FAIL scrub_addr3 got=%h want=0", rd[0 +: DW]); end
    endtask

    task automatic test_write_read();
        idle();
        we0 = 1; wa0 = 5'd5; wd0 = 32'h1234_5678;
        we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        step();
        idle();
        set_ra(0, 5'd5); set_ra(1, 5'd0);
        step();
        total++;
        if (rd[0 +: DW] !== 32'h1234_5678) begin bad++; $display("FAIL wr_rd_port0 got=%h want=12345678", rd[0 +: DW]); end
        total++;
        if (rd[DW +: DW] !== 32'h0) begin bad++; $display("FAIL zero_reg got=%h want=0", rd[DW +: DW]); end
    endtask

    task automatic test_bypass_priority();
        idle();
        we0 = 1; wa0 = 5'd7; wd0 = 32'hAAAA_AAAA;
        we1 = 1; wa1 = 5'd7; wd1 = 32'h5555_5555;
        set_ra(0, 5'd7);
        step();
        total++;
        if (rd[0 +: DW] !== 32'h5555_5555) begin bad++; $display("FAIL bypass_prio got=%h want=55555555", rd[0 +: DW]); end
        idle();
        set_ra(0, 5'd7); set_ra(2, 5'd7);
        step();
        total++;
        if (rd[0 +: DW] !== 32'h5555_5555) begin bad++; $display("FAIL stored_prio got=%h want=55555555", rd[0 +: DW]); end
        total++;
        if (rd[2*DW +: DW] !== 32'h5555_5555) begin bad++; $display("FAIL stored_prio_p2 got=%h want=55555555", rd[2*DW +: DW]); end
    endtask

    task automatic test_stall();
        idle();
        we0 = 1; wa0 = 5'd10; wd0 = 32'h22;
        we1 = 1; wa1 = 5'd11; wd1 = 32'h11;
        step();
        idle();
        set_ra(0, 5'd11);
        step();
        total++;
        if (rd[0 +: DW] !== 32'h11) begin bad++; $display("FAIL stall_pre got=%h want=11", rd[0 +: DW]); end
        for (int c = 0; c < 3; c++) begin
            stall = 1; set_ra(0, 5'd10);
            we1 = 1; wa1 = 5'd9; wd1 = 32'h33;
            step();
            total++;
            if (rd[0 +: DW] !== 32'h11) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h want=11", c, rd[0 +: DW]); end
        end
        idle();
        set_ra(0, 5'd9);
        step();
        total++;
        if (rd[0 +: DW] !== 32'h33) begin bad++; $display("FAIL stall_release got=%h want=33", rd[0 +: DW]); end
    endtask

    task automatic test_mid_reset();
        int n;
        idle();
        we0 = 1; wa0 = 5'd4; wd0 = 32'hCAFE;
        step();
        idle();
        set_ra(0, 5'd4); dbg_addr = 5'd4;
        step();
        total++;
        if (rd[0 +: DW] !== 32'hCAFE) begin bad++; $display("FAIL mid_pre got=%h want=cafe", rd[0 +: DW]); end
        rst = 1;
        step();
        rst = 0;
        total++;
        if (rd !== '0) begin bad++; $display("FAIL mid_rst_rd got=%h want=0", rd); end
        total++;
        if (dbg_data !== '0) begin bad++; $display("FAIL mid_rst_dbg got=%h want=0", dbg_data); end
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            step();
        end
        total++;
        if (n != DEPTH) begin bad++; $display("FAIL mid_scrub_len got=%0d want=%0d", n, DEPTH); end
        step();
        total++;
        if (rd[0 +: DW] !== 32'h0) begin bad++; $display("FAIL mid_addr4 got=%h want=0", rd[0 +: DW]); end
    endtask

    task automatic test_debug();
        idle();
        dbg_addr = 5'd1;
        we0 = 1; wa0 = 5'd1; wd0 = 32'hBEEF;
        for (int i = 0; i < NR; i++) set_ra(i, 5'd1);
        step();
        total++;
        if (dbg_data !== 32'hBEEF) begin bad++; $display("FAIL dbg_bypass got=%h want=beef", dbg_data); end
        idle();
        step();
        for (int i = 0; i < NR; i++) begin
            total++;
            if (rd[i*DW +: DW] !== 32'hBEEF) begin bad++; $display("FAIL dbg_rd_port%0d got=%h want=beef", i, rd[i*DW +: DW]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 3) == 0);
            we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
            wa0 = AW'($urandom_range(0, 7)); wa1 = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) wa0 = AW'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            for (int i = 0; i < NR; i++) set_ra(i, AW'($urandom_range(0, 8)));
            dbg_addr = AW'($urandom_range(0, 8));
            step();
            for (int i = 0; i < NR; i++) begin
                total++;
                if (rd[i*DW +: DW] !== exp_rd[i]) begin
                    bad++; $display("FAIL rand_rd%0d cyc=%0d got=%h want=%h", i, c, rd[i*DW +: DW], exp_rd[i]);
                end
            end
            total++;
            if (dbg_data !== exp_dbg) begin bad++; $display("FAIL rand_dbg cyc=%0d got=%h want=%h", c, dbg_data, exp_dbg); end
            total++;
            if (ready !== exp_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, ready, exp_ready); end
        end
        // Let any late scrub finish so the file ends operational.
        idle();
        for (int c = 0; c < DEPTH + 1; c++) step();
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL rand_final_ready got=%b want=1", ready); end
    endtask

    initial begin
        test_reset();
        test_scrub();
        test_write_read();
        test_bypass_priority();
        test_stall();
        test_mid_reset();
        test_debug();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
